// File: rtl/ring_pkg.sv
// Shared types and helpers for consumers of the 4-bit one-hot ring counter.
package ring_pkg;

  localparam int RING_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } ring_mon_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } ring_onehot_t;

  function automatic logic [RING_W-1:0] ring_rotl(input logic [RING_W-1:0] v);
    return {v[RING_W-2:0], v[RING_W-1]};
  endfunction

  // valid only when exactly one bit is set; idx is then the position of that bit
  function automatic ring_onehot_t ring_onehot(input logic [RING_W-1:0] v);
    ring_onehot_t r;
    int unsigned  n;
    r.valid = 1'b0;
    r.idx   = 2'd0;
    n       = 0;
    for (int i = 0; i < RING_W; i++) begin
      if (v[i]) begin
        n++;
        r.idx = 2'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary encoder for a ring counter sample.
module ring_onehot_enc
  import ring_pkg::*;
(
  input  logic [RING_W-1:0] value,
  output logic              valid,
  output logic [1:0]        index
);

  ring_onehot_t enc;

  assign enc   = ring_onehot(value);
  assign valid = enc.valid;
  assign index = enc.idx;

endmodule

// File: rtl/ring_monitor.sv
// Observes the one-hot ring counter: legality checking, lock/fault tracking,
// phase decode and revolution counting.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int REV_W       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter bit ALLOW_HOLD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RING_W-1:0] ring_q,
  input  logic              clr_count,
  input  logic              fault_ack,
  output logic [1:0]        phase,
  output logic              phase_valid,
  output logic              locked,
  output logic              fault,
  output logic [REV_W-1:0]  rev_count,
  output logic              rev_wrap
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CYCLES);

  logic [RING_W-1:0] s_q;
  logic [RING_W-1:0] p_q;
  ring_mon_state_t   state;
  ring_mon_state_t   state_next;
  logic [3:0]        good_cnt;
  logic [3:0]        good_next;
  logic [3:0]        good_inc;

  logic       onehot;
  logic [1:0] onehot_idx;
  logic       advance;
  logic       hold;
  logic       legal;
  logic       rev_inc;

  ring_onehot_enc u_enc (
    .value (s_q),
    .valid (onehot),
    .index (onehot_idx)
  );

  assign advance  = onehot && (s_q == ring_rotl(p_q));
  assign hold     = onehot && (s_q == p_q) && ALLOW_HOLD;
  assign legal    = advance || hold;
  assign good_inc = good_cnt + 4'd1;
  // an advance onto bit 0 can only come from bit 3, i.e. one full revolution
  assign rev_inc  = (state == LOCKED) && advance && (s_q == 4'b0001);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= ring_q;
      p_q <= s_q;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    case (state)
      IDLE: begin
        if (onehot) begin
          state_next = ACQUIRE;
          good_next  = 4'd0;
        end
      end
      ACQUIRE: begin
        if (advance) begin
          good_next = good_inc;
          if (good_inc == LOCK_TARGET) state_next = LOCKED;
        end else if (!hold) begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (!legal) state_next = FAULT;
      end
      FAULT: begin
        if (fault_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // phase keeps its last value across non-one-hot samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 2'd0;
    end else if (onehot) begin
      phase <= onehot_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rev_count <= '0;
      rev_wrap  <= 1'b0;
    end else if (clr_count) begin
      rev_count <= '0;
      rev_wrap  <= 1'b0;
    end else if (rev_inc) begin
      rev_count <= rev_count + REV_W'(1);
      rev_wrap  <= &rev_count;
    end else begin
      rev_wrap  <= 1'b0;
    end
  end

  assign locked      = (state == LOCKED);
  assign phase_valid = (state == LOCKED);
  assign fault       = (state == FAULT);

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: three parameterisations share one
// stimulus stream and are compared against a behavioural model.
module tb_ring_monitor;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
  localparam int M_FAULT  = 3;
  localparam int M_LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ring_q;
  logic       clr_count;
  logic       fault_ack;

  logic [1:0] phase0, phase1, phase2;
  logic       pv0, pv1, pv2, lk0, lk1, lk2, ft0, ft1, ft2, wr0, wr1, wr2;
  logic [7:0] rev0, rev2;
  logic [1:0] rev1;

  logic [13:0] obs [3];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int pos    = 0;
  logic [3:0] last_r = 4'd0;

  // model state, one entry per instance
  logic [3:0] m_s [3];
  logic [3:0] m_p [3];
  int         m_st [3];
  int         m_good [3];
  logic [1:0] m_phase [3];
  logic [7:0] m_rev [3];
  logic       m_wrap [3];

  always #5 clk = ~clk;

  ring_monitor #(.REV_W(8), .LOCK_CYCLES(4), .ALLOW_HOLD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .ring_q(ring_q), .clr_count(clr_count), .fault_ack(fault_ack),
    .phase(phase0), .phase_valid(pv0), .locked(lk0), .fault(ft0), .rev_count(rev0), .rev_wrap(wr0));

  ring_monitor #(.REV_W(2), .LOCK_CYCLES(4), .ALLOW_HOLD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ring_q(ring_q), .clr_count(clr_count), .fault_ack(fault_ack),
    .phase(phase1), .phase_valid(pv1), .locked(lk1), .fault(ft1), .rev_count(rev1), .rev_wrap(wr1));

  ring_monitor #(.REV_W(8), .LOCK_CYCLES(4), .ALLOW_HOLD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .ring_q(ring_q), .clr_count(clr_count), .fault_ack(fault_ack),
    .phase(phase2), .phase_valid(pv2), .locked(lk2), .fault(ft2), .rev_count(rev2), .rev_wrap(wr2));

  assign obs[0] = {phase0, pv0, lk0, ft0, rev0, wr0};
  assign obs[1] = {phase1, pv1, lk1, ft1, 6'd0, rev1, wr1};
  assign obs[2] = {phase2, pv2, lk2, ft2, rev2, wr2};

  function automatic int rev_bits(int k);
    return (k == 1) ? 2 : 8;
  endfunction

  function automatic bit hold_ok(int k);
    return (k != 2);
  endfunction

  function automatic logic [13:0] exp_vec(int k);
    return {m_phase[k], m_st[k] == M_LOCKED, m_st[k] == M_LOCKED, m_st[k] == M_FAULT,
            m_rev[k], m_wrap[k]};
  endfunction

  task automatic model_reset(int k);
    m_s[k] = 4'd0; m_p[k] = 4'd0; m_st[k] = M_IDLE; m_good[k] = 0;
    m_phase[k] = 2'd0; m_rev[k] = 8'd0; m_wrap[k] = 1'b0;
  endtask

  // one clock of the specification's rules, using plain arithmetic
  task automatic model_step(int k);
    logic [3:0] s, p, rl;
    int pi, maxv;
    bit oh, adv, hld, legal;
    s = m_s[k];
    p = m_p[k];
    pi = int'(p);
    rl = 4'(((pi << 1) | (pi >> 3)) & 15);
    oh = ($countones(s) == 1);
    adv = oh && (s == rl);
    hld = oh && (s == p) && hold_ok(k);
    legal = adv || hld;
    if (oh)
      for (int i = 0; i < 4; i++) if (int'(s) == (1 << i)) m_phase[k] = 2'(i);
    maxv = (1 << rev_bits(k)) - 1;
    if (clr_count) begin
      m_rev[k] = 8'd0; m_wrap[k] = 1'b0;
    end else if (m_st[k] == M_LOCKED && adv && s == 4'b0001) begin
      m_wrap[k] = (int'(m_rev[k]) == maxv);
      m_rev[k] = 8'((int'(m_rev[k]) + 1) % (maxv + 1));
    end else begin
      m_wrap[k] = 1'b0;
    end
    case (m_st[k])
      M_IDLE:   if (oh) begin m_st[k] = M_ACQ; m_good[k] = 0; end
      M_ACQ: begin
        if (adv) begin
          m_good[k] = m_good[k] + 1;
          if (m_good[k] == M_LOCK_N) m_st[k] = M_LOCKED;
        end else if (!hld) m_st[k] = M_IDLE;
      end
      M_LOCKED: if (!legal) m_st[k] = M_FAULT;
      default:  if (fault_ack) m_st[k] = M_IDLE;
    endcase
    m_p[k] = s;
    m_s[k] = ring_q;
  endtask

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) model_reset(k);
      else model_step(k);
    end
  end

  task automatic tick(input logic [3:0] r, input logic clr, input logic ack);
    ring_q = r; clr_count = clr; fault_ack = ack; last_r = r;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rot_tick(input logic clr, input logic ack);
    logic [3:0] r;
    r = 4'(1 << pos);
    pos = (pos + 1) % 4;
    tick(r, clr, ack);
  endtask

  task automatic test_reset;
    rst = 1'b0; ring_q = 4'd0; clr_count = 1'b0; fault_ack = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 14'd0) $display("[TB] FAIL reset_outputs inst%0d: got %h want 0", k, obs[k]);
      else passed++;
      checks++;
      if (obs[k] !== exp_vec(k)) $display("[TB] FAIL reset_model inst%0d: got %h want %h", k, obs[k], exp_vec(k));
      else passed++;
    end
  endtask

  task automatic test_lock;
    int exp_ph;
    rst = 1'b0; ring_q = 4'b0001; pos = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      rot_tick(1'b0, 1'b0);
      exp_ph = (n >= 2) ? (n - 2) % 4 : 0;
      checks++;
      if (lk0 !== (n >= 6)) $display("[TB] FAIL lock_edge edge%0d: got %b want %b", n, lk0, n >= 6);
      else passed++;
      checks++;
      if (phase0 !== 2'(exp_ph)) $display("[TB] FAIL lock_phase edge%0d: got %0d want %0d", n, phase0, exp_ph);
      else passed++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL lock_model inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_vec(k));
        else passed++;
      end
    end
  endtask

  task automatic test_revs;
    int seen[$];
    int wraps;
    logic [1:0] last;
    bit ok;
    rot_tick(1'b1, 1'b0);
    last = rev1; wraps = 0;
    for (int i = 0; i < 24 && seen.size() < 4; i++) begin
      rot_tick(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL revs_model inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_vec(k));
        else passed++;
      end
      if (wr1 === 1'b1) begin
        wraps++;
        checks++;
        if (rev1 !== 2'd0) $display("[TB] FAIL wrap_with_zero: got count %0d want 0", rev1);
        else passed++;
      end
      if (rev1 !== last) begin seen.push_back(int'(rev1)); last = rev1; end
    end
    ok = (seen.size() == 4) && seen[0] == 1 && seen[1] == 2 && seen[2] == 3 && seen[3] == 0;
    checks++;
    if (!ok) $display("[TB] FAIL rev_sequence: got %0d changes want 1,2,3,0", seen.size());
    else passed++;
    checks++;
    if (wraps != 1) $display("[TB] FAIL wrap_pulses: got %0d want 1", wraps);
    else passed++;
    for (int i = 0; i < 20 && rev1 !== 2'd3; i++) rot_tick(1'b0, 1'b0);
    checks++;
    if (rev1 !== 2'd3) $display("[TB] FAIL reach_three: got %0d want 3", rev1);
    else passed++;
    repeat (3) rot_tick(1'b0, 1'b0);
    rot_tick(1'b1, 1'b0);
    checks++;
    if ({rev1, wr1} !== 3'b000) $display("[TB] FAIL clr_beats_wrap: got count %0d wrap %b want 0 0", rev1, wr1);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) $display("[TB] FAIL clr_model inst%0d: got %h want %h", k, obs[k], exp_vec(k));
      else passed++;
    end
    rot_tick(1'b0, 1'b0);
    checks++;
    if (wr1 !== 1'b0) $display("[TB] FAIL wrap_after_clr: got %b want 0", wr1);
    else passed++;
  endtask

  task automatic test_fault;
    logic [7:0] frozen;
    bit relocked;
    for (int i = 0; i < 4; i++) rot_tick(1'b0, 1'b0);
    tick(4'b0110, 1'b0, 1'b0);
    checks++;
    if ({lk0, ft0} !== 2'b10) $display("[TB] FAIL fault_latency1: got lk%b ft%b want lk1 ft0", lk0, ft0);
    else passed++;
    rot_tick(1'b0, 1'b0);
    checks++;
    if ({lk0, ft0} !== 2'b01) $display("[TB] FAIL fault_latency2: got lk%b ft%b want lk0 ft1", lk0, ft0);
    else passed++;
    frozen = rev0;
    repeat (6) rot_tick(1'b0, 1'b0);
    checks++;
    if ({ft0, rev0} !== {1'b1, frozen}) $display("[TB] FAIL fault_frozen: got ft%b cnt%0d want ft1 cnt%0d", ft0, rev0, frozen);
    else passed++;
    rot_tick(1'b0, 1'b1);
    checks++;
    if (ft0 !== 1'b0) $display("[TB] FAIL fault_ack: got %b want 0", ft0);
    else passed++;
    relocked = 1'b0;
    for (int i = 0; i < 12 && !relocked; i++) begin
      rot_tick(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL relock_model inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_vec(k));
        else passed++;
      end
      relocked = (lk0 === 1'b1);
    end
    checks++;
    if (!relocked) $display("[TB] FAIL relock_timeout: got locked %b want 1", lk0);
    else passed++;
  endtask

  task automatic test_hold_skip;
    bit held_ok;
    while (pos != 1) rot_tick(1'b0, 1'b0);
    repeat (3) tick(4'b0010, 1'b0, 1'b0);
    pos = 2;
    held_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rot_tick(1'b0, 1'b0);
      if (lk0 !== 1'b1) held_ok = 1'b0;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL hold_model inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_vec(k));
        else passed++;
      end
    end
    checks++;
    if (!held_ok) $display("[TB] FAIL hold_allowed: got locked dropped want locked held");
    else passed++;
    checks++;
    if (ft2 !== 1'b1) $display("[TB] FAIL hold_forbidden: got fault %b want 1", ft2);
    else passed++;
    rot_tick(1'b0, 1'b1);
    for (int i = 0; i < 16 && !(lk0 === 1'b1 && lk2 === 1'b1); i++) rot_tick(1'b0, 1'b0);
    checks++;
    if ({lk0, lk2} !== 2'b11) $display("[TB] FAIL relock_before_skip: got %b%b want 11", lk0, lk2);
    else passed++;
    while (pos != 1) rot_tick(1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b0);
    pos = 0;
    rot_tick(1'b0, 1'b0);
    rot_tick(1'b0, 1'b0);
    checks++;
    if ({lk0, ft0} !== 2'b01) $display("[TB] FAIL skip_fault: got lk%b ft%b want lk0 ft1", lk0, ft0);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) $display("[TB] FAIL skip_model inst%0d: got %h want %h", k, obs[k], exp_vec(k));
      else passed++;
    end
  endtask

  task automatic test_acquire_illegal;
    logic [3:0] seq [10];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(seq[i], 1'b0, 1'b0);
      checks++;
      if ({ft0, ft1, ft2, lk0, lk1, lk2} !== 6'd0)
        $display("[TB] FAIL acquire_no_fault step%0d: got ft%b%b%b lk%b%b%b want all 0", i, ft0, ft1, ft2, lk0, lk1, lk2);
      else passed++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL acquire_model inst%0d step%0d: got %h want %h", k, i, obs[k], exp_vec(k));
        else passed++;
      end
    end
    pos = 3;
  endtask

  task automatic test_async_reset;
    bit relocked;
    for (int i = 0; i < 20 && lk0 !== 1'b1; i++) rot_tick(1'b0, 1'b0);
    rot_tick(1'b1, 1'b0);
    for (int i = 0; i < 40 && rev0 !== 8'd5; i++) rot_tick(1'b0, 1'b0);
    checks++;
    if ({lk0, rev0} !== {1'b1, 8'd5}) $display("[TB] FAIL async_setup: got lk%b cnt%0d want lk1 cnt5", lk0, rev0);
    else passed++;
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 14'd0) $display("[TB] FAIL async_reset inst%0d: got %h want 0", k, obs[k]);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b1;
    relocked = 1'b0;
    for (int i = 0; i < 12 && !relocked; i++) begin
      rot_tick(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL async_relock_model inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_vec(k));
        else passed++;
      end
      relocked = (lk0 === 1'b1);
    end
    checks++;
    if ({relocked, rev0} !== {1'b1, 8'd0}) $display("[TB] FAIL async_relock: got lk%b cnt%0d want lk1 cnt0", lk0, rev0);
    else passed++;
  endtask

  task automatic test_random;
    int c;
    logic clr, ack;
    for (int i = 0; i < 300; i++) begin
      c = int'($urandom_range(0, 19));
      clr = ($urandom_range(0, 31) == 0);
      ack = ($urandom_range(0, 7) == 0);
      if (c < 14) rot_tick(clr, ack);
      else if (c < 16) tick(last_r, clr, ack);
      else if (c < 18) tick(4'($urandom_range(0, 15)), clr, ack);
      else if (c == 18) tick(4'b0000, clr, ack);
      else begin
        pos = int'($urandom_range(0, 3));
        rot_tick(clr, ack);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) $display("[TB] FAIL random_model inst%0d cyc%0d: got %h want %h", k, cyc, obs[k], exp_vec(k));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_revs;
    test_fault;
    test_hold_skip;
    test_acquire_illegal;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
